hazard_stall_ctrl: RTL and testbench
====================================

HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

Interface
REQ-001 Parameter WDOG_LIMIT, default 8, is the number of consecutive stall cycles after which the watchdog trips.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 ID_rs, ID_rt  in  5 each  source registers of the instruction in ID.
REQ-005 ID_useRs, ID_useRt  in  1 each  instruction in ID reads rs / rt (in any stage).
REQ-006 ID_Branch, ID_Jump  in  2 each  ID control, encoded per ctrl_encode_def.v.
REQ-007 ID_branchTaken  in  1  ID-resolved branch is taken (meaningful only when ID_Branch != BRANCH_NONE).
REQ-008 EX_RegWrite, EX_RegSrc(2), EX_WriteReg(5)  in  write-back info of the instruction in EX.
REQ-009 MEM_RegWrite, MEM_RegSrc(2), MEM_WriteReg(5)  in  write-back info of the instruction in MEM.
REQ-010 dmem_busy  in  1  data memory is not ready; the whole pipeline must hold.
REQ-011 PC_write, IFID_write  out  1 each  enables for the PC and IF/ID registers.
REQ-012 IFID_flush, IDEX_bubble  out  1 each  IF/ID cleared to NOP; ID/EX loaded with NOP.
REQ-013 hz_state  out  2  registered FSM state (RUN=0, STALL=1, FREEZE=2, FLUSH=3).
REQ-014 wdog_err  out  1  sticky watchdog flag.

Function
REQ-015 useAtID SHALL be (ID_Branch != BRANCH_NONE) || (ID_Jump == JUMP_REG).
REQ-016 A hit on stage X for operand r SHALL require X_RegWrite, X_WriteReg != 0, X_WriteReg == r, and r in use (ID_useRs / ID_useRt).
REQ-017 dataStall SHALL assert on: EX hit with EX_RegSrc == REGSRC_DMEM; EX hit with EX_RegSrc == REGSRC_ALU while useAtID; MEM hit with MEM_RegSrc == REGSRC_DMEM while useAtID.
REQ-018 An EX or MEM hit with RegSrc == REGSRC_PCPLUS4 SHALL never stall.
REQ-019 redirect SHALL be ((ID_Branch != BRANCH_NONE) && ID_branchTaken) || (ID_Jump != JUMP_NONE).
REQ-020 Priority SHALL be dmem_busy > dataStall > redirect.
REQ-021 dmem_busy=1: PC_write=0, IFID_write=0, IDEX_bubble=0, IFID_flush=0; next state FREEZE.
REQ-022 dataStall (no dmem_busy): PC_write=0, IFID_write=0, IDEX_bubble=1, IFID_flush=0; next state STALL.
REQ-023 redirect only: PC_write=1, IFID_write=1, IFID_flush=1, IDEX_bubble=0; next state FLUSH.
REQ-024 Otherwise: PC_write=1, IFID_write=1, flush=0, bubble=0; next state RUN.
REQ-025 Control outputs SHALL be combinational in the same cycle; hz_state SHALL be the registered next state (one-cycle latency).
REQ-026 A 4-bit saturating stall-run counter SHALL increment each cycle in which dataStall or dmem_busy is active, and clear on any cycle with neither.
REQ-027 wdog_err SHALL set when the counter reaches WDOG_LIMIT, stay set until rst, and not alter the stall outputs.

Reset
REQ-028 When rst=1 at a clock edge, hz_state SHALL become RUN, the stall-run counter 0, and wdog_err 0.
REQ-029 Combinational outputs SHALL follow REQ-021..024 during reset; a reset in mid-stall SHALL discard the run count.

Configuration
REQ-030 With macro HAZARD_PERF_EN defined: 32-bit outputs stall_cycles and flush_count SHALL count dataStall/dmem_busy cycles and IFID_flush cycles, saturating at 0xFFFFFFFF and cleared by rst.
REQ-031 Without HAZARD_PERF_EN: those ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-032 Load-use: EX RegWrite=1, RegSrc=DMEM, WriteReg=5; ID_rs=5, useRs=1 -> PC_write=0, IDEX_bubble=1; next cycle hz_state=STALL.
REQ-033 beq in ID, rt=3; EX writes r3 via ALU -> stall; same case with RegSrc=PCPLUS4 -> no stall, and taken -> IFID_flush=1, hz_state=FLUSH.
REQ-034 WriteReg=0 with matching rs=0 -> no stall in any stage combination.
REQ-035 dmem_busy=1 together with dataStall and redirect -> freeze only (bubble=0, flush=0); hz_state=FREEZE.
REQ-036 Hold dmem_busy for 8 cycles with WDOG_LIMIT=8 -> wdog_err rises after the 8th edge, stays 1 after busy drops, and clears only on rst.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Hazard / stall controller for a 5-stage pipeline: load-use and ID-branch stalls, memory freeze, redirect flush, stall watchdog.
// Optional performance counters are compiled in when HAZARD_PERF_EN is defined.
module hazard_stall_ctrl #(
  parameter int WDOG_LIMIT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] ID_rs,
  input  logic [4:0] ID_rt,
  input  logic       ID_useRs,
  input  logic       ID_useRt,
  input  logic [1:0] ID_Branch,
  input  logic [1:0] ID_Jump,
  input  logic       ID_branchTaken,
  input  logic       EX_RegWrite,
  input  logic [1:0] EX_RegSrc,
  input  logic [4:0] EX_WriteReg,
  input  logic       MEM_RegWrite,
  input  logic [1:0] MEM_RegSrc,
  input  logic [4:0] MEM_WriteReg,
  input  logic       dmem_busy,
  output logic       PC_write,
  output logic       IFID_write,
  output logic       IFID_flush,
  output logic       IDEX_bubble,
  output logic [1:0] hz_state,
  output logic       wdog_err
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
`endif
);

  // Control encodings shared with the decoder.
  localparam logic [1:0] BRANCH_NONE    = 2'd0;
  localparam logic [1:0] JUMP_NONE      = 2'd0;
  localparam logic [1:0] JUMP_REG       = 2'd2;
  localparam logic [1:0] REGSRC_ALU     = 2'd0;
  localparam logic [1:0] REGSRC_DMEM    = 2'd1;
  localparam logic [1:0] REGSRC_PCPLUS4 = 2'd2;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL  = 2'd1,
    FREEZE = 2'd2,
    FLUSH  = 2'd3
  } hzState_t;

  hzState_t   stateReg, stateNext;
  logic [3:0] runCntReg, runCntNext;
  logic       wdogErrReg;

  logic useAtId, exHit, memHit, dataStall, redirect, stallActive;

  always_comb begin
    useAtId = (ID_Branch != BRANCH_NONE) || (ID_Jump == JUMP_REG);
    exHit   = EX_RegWrite && (EX_WriteReg != 5'd0) &&
              (((EX_WriteReg == ID_rs) && ID_useRs) || ((EX_WriteReg == ID_rt) && ID_useRt));
    memHit  = MEM_RegWrite && (MEM_WriteReg != 5'd0) &&
              (((MEM_WriteReg == ID_rs) && ID_useRs) || ((MEM_WriteReg == ID_rt) && ID_useRt));
    // PC+4 results are available from the link path, so they never cause a stall.
    dataStall = (exHit && (EX_RegSrc == REGSRC_DMEM)) ||
                (exHit && (EX_RegSrc == REGSRC_ALU) && useAtId) ||
                (memHit && (MEM_RegSrc == REGSRC_DMEM) && useAtId);
    redirect  = ((ID_Branch != BRANCH_NONE) && ID_branchTaken) || (ID_Jump != JUMP_NONE);
    stallActive = dataStall || dmem_busy;
  end

  always_comb begin
    PC_write    = 1'b1;
    IFID_write  = 1'b1;
    IFID_flush  = 1'b0;
    IDEX_bubble = 1'b0;
    stateNext   = RUN;
    if (dmem_busy) begin
      PC_write   = 1'b0;
      IFID_write = 1'b0;
      stateNext  = FREEZE;
    end else if (dataStall) begin
      PC_write    = 1'b0;
      IFID_write  = 1'b0;
      IDEX_bubble = 1'b1;
      stateNext   = STALL;
    end else if (redirect) begin
      IFID_flush = 1'b1;
      stateNext  = FLUSH;
    end
  end

  always_comb begin
    runCntNext = 4'd0;
    if (stallActive) begin
      runCntNext = (runCntReg == 4'hF) ? 4'hF : runCntReg + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg   <= RUN;
      runCntReg  <= 4'd0;
      wdogErrReg <= 1'b0;
    end else begin
      stateReg   <= stateNext;
      runCntReg  <= runCntNext;
      wdogErrReg <= wdogErrReg || (32'(runCntNext) == 32'(WDOG_LIMIT));
    end
  end

  assign hz_state = stateReg;
  assign wdog_err = wdogErrReg;

`ifdef HAZARD_PERF_EN
  logic [31:0] stallCyclesReg, flushCountReg;

  always_ff @(posedge clk) begin
    if (rst) begin
      stallCyclesReg <= 32'd0;
      flushCountReg  <= 32'd0;
    end else begin
      if (stallActive && (stallCyclesReg != 32'hFFFF_FFFF)) stallCyclesReg <= stallCyclesReg + 32'd1;
      if (IFID_flush && (flushCountReg != 32'hFFFF_FFFF)) flushCountReg <= flushCountReg + 32'd1;
    end
  end

  assign stall_cycles = stallCyclesReg;
  assign flush_count  = flushCountReg;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed scenarios plus randomized traffic against a rule-level model.
module tb_hazard_stall_ctrl;
  localparam int LIMIT = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] ID_rs, ID_rt;
  logic       ID_useRs, ID_useRt;
  logic [1:0] ID_Branch, ID_Jump;
  logic       ID_branchTaken;
  logic       EX_RegWrite;
  logic [1:0] EX_RegSrc;
  logic [4:0] EX_WriteReg;
  logic       MEM_RegWrite;
  logic [1:0] MEM_RegSrc;
  logic [4:0] MEM_WriteReg;
  logic       dmem_busy;
  logic       PC_write, IFID_write, IFID_flush, IDEX_bubble;
  logic [1:0] hz_state;
  logic       wdog_err;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles, flush_count;
`endif

  hazard_stall_ctrl #(.WDOG_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_useRs(ID_useRs), .ID_useRt(ID_useRt),
    .ID_Branch(ID_Branch), .ID_Jump(ID_Jump), .ID_branchTaken(ID_branchTaken),
    .EX_RegWrite(EX_RegWrite), .EX_RegSrc(EX_RegSrc), .EX_WriteReg(EX_WriteReg),
    .MEM_RegWrite(MEM_RegWrite), .MEM_RegSrc(MEM_RegSrc), .MEM_WriteReg(MEM_WriteReg),
    .dmem_busy(dmem_busy),
    .PC_write(PC_write), .IFID_write(IFID_write), .IFID_flush(IFID_flush), .IDEX_bubble(IDEX_bubble),
    .hz_state(hz_state), .wdog_err(wdog_err)
`ifdef HAZARD_PERF_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  int m_state = 0;
  int m_cnt   = 0;
  bit m_wdog  = 0;

  wire [3:0] ctl = {PC_write, IFID_write, IFID_flush, IDEX_bubble};

  function automatic bit reads(logic we, logic [4:0] wr, logic [4:0] r, logic use_r);
    return we && (wr != 5'd0) && (wr == r) && use_r;
  endfunction

  function automatic bit model_data_stall();
    bit at_id, ex, mem;
    at_id = (ID_Branch != 2'd0) || (ID_Jump == 2'd2);
    ex  = reads(EX_RegWrite, EX_WriteReg, ID_rs, ID_useRs) || reads(EX_RegWrite, EX_WriteReg, ID_rt, ID_useRt);
    mem = reads(MEM_RegWrite, MEM_WriteReg, ID_rs, ID_useRs) || reads(MEM_RegWrite, MEM_WriteReg, ID_rt, ID_useRt);
    return (ex && EX_RegSrc == 2'd1) || (ex && EX_RegSrc == 2'd0 && at_id) || (mem && MEM_RegSrc == 2'd1 && at_id);
  endfunction

  // Returns {PC_write, IFID_write, IFID_flush, IDEX_bubble, next_state}.
  function automatic logic [5:0] model_comb();
    bit redir;
    redir = ((ID_Branch != 2'd0) && ID_branchTaken) || (ID_Jump != 2'd0);
    if (dmem_busy) return {4'b0000, 2'd2};
    if (model_data_stall()) return {4'b0001, 2'd1};
    if (redir) return {4'b1110, 2'd3};
    return {4'b1100, 2'd0};
  endfunction

  task automatic tick();
    logic [5:0] e;
    bit active;
    e = model_comb();
    active = dmem_busy || model_data_stall();
    if (rst) begin
      m_state = 0; m_cnt = 0; m_wdog = 0;
    end else begin
      m_state = int'(e[1:0]);
      m_cnt = active ? ((m_cnt < 15) ? m_cnt + 1 : 15) : 0;
      if (m_cnt == LIMIT) m_wdog = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ID_rs = 0; ID_rt = 0; ID_useRs = 0; ID_useRt = 0;
    ID_Branch = 0; ID_Jump = 0; ID_branchTaken = 0;
    EX_RegWrite = 0; EX_RegSrc = 0; EX_WriteReg = 0;
    MEM_RegWrite = 0; MEM_RegSrc = 0; MEM_WriteReg = 0;
    dmem_busy = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1; dmem_busy = 1;
    #2;
    n_checks++;
    if (ctl !== 4'b0000) begin n_fail++; $display("FAIL reset_comb_freeze: got %b expected 0000", ctl); end
    tick();
    n_checks++;
    if (hz_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", hz_state); end
    n_checks++;
    if (wdog_err !== 1'b0) begin n_fail++; $display("FAIL reset_wdog: got %b expected 0", wdog_err); end
    rst = 0; dmem_busy = 0;
    #2;
    n_checks++;
    if (ctl !== 4'b1100) begin n_fail++; $display("FAIL idle_comb: got %b expected 1100", ctl); end
    tick();
    n_checks++;
    if (hz_state !== 2'd0) begin n_fail++; $display("FAIL idle_state: got %0d expected 0", hz_state); end
  endtask

  task automatic test_load_use();
    clear_inputs();
    EX_RegWrite = 1; EX_RegSrc = 2'd1; EX_WriteReg = 5'd5; ID_rs = 5'd5; ID_useRs = 1;
    #2;
    n_checks++;
    if (ctl !== 4'b0001) begin n_fail++; $display("FAIL load_use_comb: got %b expected 0001", ctl); end
    tick();
    n_checks++;
    if (hz_state !== 2'd1) begin n_fail++; $display("FAIL load_use_state: got %0d expected 1", hz_state); end
  endtask

  task automatic test_branch();
    clear_inputs();
    ID_Branch = 2'd1; ID_rt = 5'd3; ID_useRt = 1;
    EX_RegWrite = 1; EX_RegSrc = 2'd0; EX_WriteReg = 5'd3;
    #2;
    n_checks++;
    if (ctl !== 4'b0001) begin n_fail++; $display("FAIL branch_alu_stall: got %b expected 0001", ctl); end
    tick();
    EX_RegSrc = 2'd2;
    #2;
    n_checks++;
    if (ctl !== 4'b1100) begin n_fail++; $display("FAIL branch_pc4_nostall: got %b expected 1100", ctl); end
    ID_branchTaken = 1;
    #1;
    n_checks++;
    if (ctl !== 4'b1110) begin n_fail++; $display("FAIL branch_taken_flush: got %b expected 1110", ctl); end
    tick();
    n_checks++;
    if (hz_state !== 2'd3) begin n_fail++; $display("FAIL branch_flush_state: got %0d expected 3", hz_state); end
    // MEM load feeding a jr must stall; a plain ALU consumer of the same load must not.
    clear_inputs();
    ID_Jump = 2'd2; ID_rs = 5'd9; ID_useRs = 1;
    MEM_RegWrite = 1; MEM_RegSrc = 2'd1; MEM_WriteReg = 5'd9;
    #2;
    n_checks++;
    if (ctl !== 4'b0001) begin n_fail++; $display("FAIL jr_mem_load_stall: got %b expected 0001", ctl); end
    ID_Jump = 2'd0;
    #1;
    n_checks++;
    if (ctl !== 4'b1100) begin n_fail++; $display("FAIL alu_mem_load_nostall: got %b expected 1100", ctl); end
    tick();
  endtask

  task automatic test_zero_reg();
    clear_inputs();
    ID_Branch = 2'd1; ID_useRs = 1; ID_useRt = 1;
    EX_RegWrite = 1; MEM_RegWrite = 1;
    for (int ex_src = 0; ex_src < 3; ex_src++) begin
      for (int mem_src = 0; mem_src < 3; mem_src++) begin
        EX_RegSrc = 2'(ex_src); MEM_RegSrc = 2'(mem_src);
        #2;
        n_checks++;
        if (ctl !== 4'b1100) begin
          n_fail++;
          $display("FAIL zero_reg ex_src=%0d mem_src=%0d: got %b expected 1100", ex_src, mem_src, ctl);
        end
        tick();
      end
    end
  endtask

  task automatic test_freeze_priority();
    clear_inputs();
    EX_RegWrite = 1; EX_RegSrc = 2'd1; EX_WriteReg = 5'd7; ID_rs = 5'd7; ID_useRs = 1;
    ID_Jump = 2'd1; dmem_busy = 1;
    #2;
    n_checks++;
    if (ctl !== 4'b0000) begin n_fail++; $display("FAIL freeze_priority_comb: got %b expected 0000", ctl); end
    tick();
    n_checks++;
    if (hz_state !== 2'd2) begin n_fail++; $display("FAIL freeze_state: got %0d expected 2", hz_state); end
    dmem_busy = 0;
    #2;
    n_checks++;
    if (ctl !== 4'b0001) begin n_fail++; $display("FAIL stall_over_redirect: got %b expected 0001", ctl); end
    tick();
  endtask

  task automatic test_watchdog();
    clear_inputs();
    rst = 1; tick(); rst = 0;
    dmem_busy = 1;
    for (int i = 1; i <= LIMIT; i++) begin
      tick();
      n_checks++;
      if (wdog_err !== (i >= LIMIT)) begin
        n_fail++;
        $display("FAIL wdog_rise edge=%0d: got %b expected %b", i, wdog_err, (i >= LIMIT));
      end
    end
    dmem_busy = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (wdog_err !== 1'b1) begin n_fail++; $display("FAIL wdog_sticky cycle=%0d: got %b expected 1", i, wdog_err); end
    end
    rst = 1; tick(); rst = 0;
    n_checks++;
    if (wdog_err !== 1'b0) begin n_fail++; $display("FAIL wdog_clear_on_rst: got %b expected 0", wdog_err); end
  endtask

  task automatic test_reset_midstall();
    clear_inputs();
    dmem_busy = 1;
    for (int i = 0; i < 5; i++) tick();
    rst = 1; tick(); rst = 0;
    for (int i = 1; i <= LIMIT; i++) begin
      tick();
      n_checks++;
      if (wdog_err !== (i >= LIMIT)) begin
        n_fail++;
        $display("FAIL midstall_reset edge=%0d: got %b expected %b", i, wdog_err, (i >= LIMIT));
      end
    end
    dmem_busy = 0;
    rst = 1; tick(); rst = 0;
  endtask

  task automatic test_random();
    logic [5:0] e;
    for (int it = 0; it < 400; it++) begin
      rst            = ($urandom_range(0, 24) == 0);
      ID_rs          = 5'($urandom_range(0, 3));
      ID_rt          = 5'($urandom_range(0, 3));
      ID_useRs       = 1'($urandom);
      ID_useRt       = 1'($urandom);
      ID_Branch      = 2'($urandom);
      ID_Jump        = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'd0;
      ID_branchTaken = 1'($urandom);
      EX_RegWrite    = 1'($urandom);
      EX_RegSrc      = 2'($urandom_range(0, 2));
      EX_WriteReg    = 5'($urandom_range(0, 3));
      MEM_RegWrite   = 1'($urandom);
      MEM_RegSrc     = 2'($urandom_range(0, 2));
      MEM_WriteReg   = 5'($urandom_range(0, 3));
      dmem_busy      = ($urandom_range(0, 2) == 0);
      #2;
      e = model_comb();
      n_checks++;
      if (ctl !== e[5:2]) begin n_fail++; $display("FAIL random_comb it=%0d: got %b expected %b", it, ctl, e[5:2]); end
      tick();
      n_checks++;
      if (hz_state !== 2'(m_state)) begin n_fail++; $display("FAIL random_state it=%0d: got %0d expected %0d", it, hz_state, m_state); end
      n_checks++;
      if (wdog_err !== m_wdog) begin n_fail++; $display("FAIL random_wdog it=%0d: got %b expected %b", it, wdog_err, m_wdog); end
    end
    rst = 0;
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    tick();
    tick();
    test_reset();
    test_load_use();
    test_branch();
    test_zero_reg();
    test_freeze_priority();
    test_watchdog();
    test_reset_midstall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
